// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Request and response each use a valid/ready handshake; divide-by-zero and overflow finish immediately.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic            op_rem, neg_q, neg_r;
  logic [XLEN-1:0] divisor, quo, rem;

  logic            is_signed, a_neg, b_neg, div_zero, overflow, special, last;
  logic [XLEN-1:0] a_abs, b_abs, special_res;
  logic [XLEN:0]   rem_shift, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix;

  // Operand conditioning at the accept edge
  always_comb begin
    is_signed   = ~req_op[0];
    a_neg       = is_signed & req_a[XLEN-1];
    b_neg       = is_signed & req_b[XLEN-1];
    a_abs       = a_neg ? -req_a : req_a;
    b_abs       = b_neg ? -req_b : req_b;
    div_zero    = (req_b == '0);
    overflow    = is_signed & (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (&req_b);
    special     = div_zero | overflow;
    if (div_zero) special_res = req_op[1] ? req_a : '1;
    else          special_res = req_op[1] ? '0 : req_a;
  end

  // One restoring step: shift remainder:dividend left, trial-subtract |b|
  always_comb begin
    rem_shift = {rem, quo[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor};
    q_bit     = ~diff[XLEN];
    rem_step  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_step  = {quo[XLEN-2:0], q_bit};
    q_fix     = neg_q ? -quo_step : quo_step;
    r_fix     = neg_r ? -rem_step : rem_step;
    last      = (count == CW'(XLEN - 1));
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      op_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      divisor   <= '0;
      quo       <= '0;
      rem       <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_rem  <= req_op[1];
            neg_q   <= is_signed & (req_a[XLEN-1] ^ req_b[XLEN-1]);
            neg_r   <= a_neg;
            divisor <= b_abs;
            quo     <= a_abs;
            rem     <= '0;
            count   <= '0;
            if (special) resp_data <= special_res;
          end
        end
        S_CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          // Saturates at XLEN; the last step always leaves CALC
          if (count != CW'(XLEN)) count <= count + 1'b1;
          if (last) resp_data <= op_rem ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, backpressure, mid-CALC reset,
// and randomized operations against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b, resp_data;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain integer arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] res;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    res = op[1] ? r[31:0] : q[31:0];
    return res;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the result, hold backpressure for 'hold' cycles, then retire it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int idle, input int hold, input bit junk_while_busy);
    logic [31:0] exp_data;
    int          exp_lat, lat, n;
    bit          ready_before, accepted, got;
    exp_data = ref_div(op, a, b);
    // Edges after the accept edge until resp_valid is seen: 0 means high in the first cycle after accept
    exp_lat  = is_special(op, a, b) ? 0 : 32;
    for (int i = 0; i < idle; i++) tick();
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 50) begin
      ready_before = req_ready;
      tick();
      accepted = ready_before;
      n++;
    end
    if (!accepted) begin
      check({tag, " accept timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_valid = junk_while_busy ? 1'($urandom) : 1'b0;
    req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
    lat = 0;
    got = resp_valid;
    while (!got && lat < 40) begin
      tick();
      lat++;
      got = resp_valid;
      if (junk_while_busy) begin
        req_valid = 1'($urandom); req_op = 2'($urandom); req_a = $urandom; req_b = $urandom;
      end
    end
    if (!got) begin
      check({tag, " resp timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, resp_data, exp_data);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, " hold data"}, resp_data, exp_data);
      check({tag, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, " retire valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " retire req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel, n;
    bit          ready_before, accepted;

    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 2'b00; req_a = 32'd0; req_b = 32'd0;
    #1;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_data", resp_data, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 0, 0, 0);
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 1, 0, 0);
    run_op("div -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op("rem -7/2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op("div 7/-2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 0, 0, 0);
    run_op("rem 7/-2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 0, 0, 0);
    run_op("divu 5/0",   OP_DIVU, 32'd5, 32'd0, 0, 0, 0);
    run_op("rem 5/0",    OP_REM,  32'd5, 32'd0, 0, 0, 0);
    run_op("div ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("rem ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("divu ovf-pattern", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("backpressure", OP_DIV, 32'd1000, 32'hFFFF_FFF9, 0, 10, 1);

    // Reset in the middle of CALC aborts the division without a response
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd123456; req_b = 32'd10;
    accepted = 1'b0; n = 0;
    while (!accepted && n < 50) begin
      ready_before = req_ready;
      tick();
      accepted = ready_before;
      n++;
    end
    req_valid = 1'b0;
    check("abort accepted", {31'd0, accepted}, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    check("abort busy before rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort req_ready", {31'd0, req_ready}, 32'd1);
    check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort resp_data", resp_data, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("abort no response", {31'd0, resp_valid}, 32'd0);
    run_op("divu 9/3 after rst", OP_DIVU, 32'd9, 32'd3, 0, 0, 0);

    for (int k = 0; k < 2000; k++) begin
      op  = 2'($urandom);
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'd0;
        3: begin a = $urandom >> 12; b = $urandom | 32'h4000_0000; end
        4: begin
          a = $urandom_range(0, 255); b = $urandom_range(1, 15);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      run_op("random", op, a, b, $urandom_range(0, 1), $urandom_range(0, 2), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
